wsa_feeder: RTL and testbench
=============================

Name: wsa_feeder

Overview:
- Upstream stage of the 4x4 weight-stationary MMU.
- Accepts an N-row weight tile, then a stream of unskewed N-lane activation vectors, both over valid/ready.
- Drives the MMU's control, wt_arr and data_arr ports, so external logic never hand-skews data.
- Applies the diagonal skew (lane i delayed i cycles), zero-fills bubbles and drain, and flags tile completion.

Parameters:
- N, 4, array dimension: lanes per vector and weight rows per tile.
- DW, 8, bits per lane element.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wt_in  in  N*DW  weight row; lane i = bits [i*DW +: DW].
- wt_valid  in  1  wt_in valid.
- wt_ready  out  1  feeder accepts a weight row this cycle.
- act_in  in  N*DW  unskewed activation vector; lane 0 = LSB byte.
- act_valid  in  1  act_in valid.
- act_last  in  1  marks the final vector of the tile; qualified by act_valid.
- act_ready  out  1  feeder accepts an activation vector this cycle.
- control  out  1  to MMU: 1 = the wt_arr row is loaded this cycle.
- wt_arr  out  N*DW  to MMU: weight row.
- data_arr  out  N*DW  to MMU: skewed activation lanes.
- data_vld  out  N  per-lane valid, skewed identically to data_arr; for downstream accumulator capture.
- busy  out  1  state != IDLE.
- tile_done  out  1  one-cycle pulse when the last lane of the last vector is on data_arr.

Behaviour:
- Reset (asynchronous, active low): every output register clears to 0.
  - control=0, wt_arr=0, data_arr=0, data_vld=0, tile_done=0, busy=0.
  - All skew registers clear; the FSM goes to IDLE; the row counter clears.
- A reset asserted mid-tile discards all in-flight data; no tile_done is produced for that tile.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN.
- wt_ready = (state==IDLE || state==LOAD_W).
- act_ready = (state==STREAM).
- Weight accept = wt_valid && wt_ready.
  - Next cycle: control=1 and wt_arr=wt_in (1-cycle registered latency).
  - Cycles without an accept: control=0, wt_arr holds its last value.
  - Rows are forwarded in arrival order; row-to-PE mapping belongs to the MMU.
- Row counter (0..N-1) increments on each accept.
  - IDLE -> LOAD_W on the first accept.
  - LOAD_W -> STREAM on the accept of row N-1; the counter returns to 0.
  - When N=1, IDLE goes directly to STREAM.
- Activation accept at cycle t: lane i of act_in appears on data_arr lane i at cycle t+1+i, with data_vld[i]=1.
- Lane 0 has one register; lane i has i+1 registers.
- In any STREAM cycle with no accept, a zero bubble (data 0, vld 0) enters all lanes. The skew therefore never stalls and lane timing stays fixed.
- STREAM -> DRAIN on an accept with act_last=1. In the same cycle, a drain counter loads N-1.
- DRAIN:
  - No accepts.
  - Zero bubbles are injected.
  - The counter decrements each cycle.
  - At 0 the FSM goes to IDLE and tile_done pulses that cycle, i.e. at cycle t_last+N, aligned with lane N-1 of the last vector.
  - For N=1, tile_done pulses at t_last+1.
- control is 0 in STREAM and DRAIN. data_arr is 0 in IDLE and LOAD_W, since the skew pipe is empty on leaving DRAIN.
- wt_valid during STREAM or DRAIN is ignored (wt_ready=0), and the row is held by the source.
- act_valid outside STREAM is ignored.
- act_last without act_valid has no effect.
- A new weight load may be accepted on the cycle after tile_done (back-to-back tiles).

Decomposition:
- Package wsa_pkg holds:
  - the state enum typedef (IDLE, LOAD_W, STREAM, DRAIN);
  - localparams N_DEF=4 and DW_DEF=8;
  - the function lane_delay(i) = i.
- One sub-module, wsa_skew_lane:
  - parameters DW and DELAY;
  - a (DELAY+1)-stage shift register of {vld, data} with asynchronous active-low clear;
  - instantiated N times in a generate loop.

Test Plan:
- Reset state: hold reset=0 -> all outputs 0, wt_ready=0, act_ready=0. Release reset -> wt_ready=1, busy=0.
- Weight load: rows 05020304, 03010203, 07040102, 01020403 sent back-to-back -> control=1 for 4 consecutive cycles, one cycle after each accept, with wt_arr equal to the rows in order; act_ready rises the cycle after the 4th accept.
- Skew: vectors 00010101, 02010202, 04030100, 05010200 (last on 4th) sent back-to-back -> data_arr = 00000001, 00000102, 00010200, 00010100, 02030200, 04010000, 05000000 on consecutive cycles; tile_done on the 05000000 cycle; then IDLE with data_arr=0.
- Bubble: drop act_valid for 2 cycles between vectors 1 and 2 -> two all-zero diagonals inserted, with data_vld=0 on those lanes and timing shifted by 2; tile_done is 2 cycles later than in the skew scenario.
- Gaps and ignores: wt_valid toggled 1,0,1,0,... -> control=0 in gap cycles, wt_arr held, 4 rows total; wt_valid=1 during STREAM -> wt_ready=0 and no control pulse.
- Reset mid-stream: assert reset after vector 2 is accepted -> outputs clear immediately with no tile_done; after release, a fresh 4-row load plus 1 vector (act_last) gives tile_done 4 cycles after the vector accept.

Source files
------------

// File: rtl/wsa_pkg.sv
// Shared types and defaults for the weight-stationary array feeder.
package wsa_pkg;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN
  } state_t;

  // Lane i of an activation vector reaches the array i cycles after lane 0.
  function automatic int unsigned lane_delay(input int unsigned i);
    return i;
  endfunction

endpackage

// File: rtl/wsa_skew_lane.sv
// One activation lane of the diagonal skew: (DELAY+1)-stage shift of {vld, data}.
module wsa_skew_lane #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DELAY = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vld_in,
  input  logic [DW-1:0] data_in,
  output logic          vld_out,
  output logic [DW-1:0] data_out
);

  logic [DW:0] pipe [DELAY+1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < DELAY + 1; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= {vld_in, data_in};
      for (int unsigned k = 1; k < DELAY + 1; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign {vld_out, data_out} = pipe[DELAY];

endmodule

// File: rtl/wsa_feeder.sv
// Feeds a weight tile then diagonally skewed activation vectors into the MMU.
module wsa_feeder
  import wsa_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N*DW-1:0] wt_in,
  input  logic          wt_valid,
  output logic          wt_ready,
  input  logic [N*DW-1:0] act_in,
  input  logic          act_valid,
  input  logic          act_last,
  output logic          act_ready,
  output logic          control,
  output logic [N*DW-1:0] wt_arr,
  output logic [N*DW-1:0] data_arr,
  output logic [N-1:0]  data_vld,
  output logic          busy,
  output logic          tile_done
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state, state_nx;
  logic [CW-1:0] row_cnt, row_nx;
  logic [CW-1:0] drn_cnt, drn_nx;
  logic          wt_acc, act_acc;

  // Readies are masked by reset so nothing looks acceptable while held in reset.
  assign wt_ready  = reset && ((state == IDLE) || (state == LOAD_W));
  assign act_ready = reset && (state == STREAM);
  assign wt_acc    = wt_valid && wt_ready;
  assign act_acc   = act_valid && act_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx  = state;
    row_nx    = row_cnt;
    drn_nx    = drn_cnt;
    tile_done = 1'b0;
    case (state)
      IDLE, LOAD_W: begin
        if (wt_acc) begin
          if (row_cnt == LAST) begin
            state_nx = STREAM;
            row_nx   = '0;
          end else begin
            state_nx = LOAD_W;
            row_nx   = row_cnt + 1'b1;
          end
        end
      end
      STREAM: begin
        if (act_acc && act_last) begin
          state_nx = DRAIN;
          drn_nx   = LAST;
        end
      end
      DRAIN: begin
        if (drn_cnt == '0) begin
          state_nx  = IDLE;
          tile_done = 1'b1;
        end else begin
          drn_nx = drn_cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      row_cnt <= '0;
      drn_cnt <= '0;
      control <= 1'b0;
      wt_arr  <= '0;
    end else begin
      state   <= state_nx;
      row_cnt <= row_nx;
      drn_cnt <= drn_nx;
      control <= wt_acc;
      if (wt_acc) wt_arr <= wt_in;
    end
  end

  // Non-accept cycles push a zero bubble so the diagonal timing never shifts.
  for (genvar i = 0; i < N; i++) begin : g_lane
    wsa_skew_lane #(
      .DW    (DW),
      .DELAY (lane_delay(i))
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .vld_in   (act_acc),
      .data_in  (act_acc ? act_in[i*DW +: DW] : '0),
      .vld_out  (data_vld[i]),
      .data_out (data_arr[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_wsa_feeder.sv
// Scoreboard bench for wsa_feeder: expectations queued at accept, checked per cycle.
module tb_wsa_feeder;

  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct {
    int unsigned cyc;
    logic [31:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   wt_in = '0;
  logic          wt_valid = 1'b0;
  logic          wt_ready;
  logic [31:0]   act_in = '0;
  logic          act_valid = 1'b0;
  logic          act_last = 1'b0;
  logic          act_ready;
  logic          control;
  logic [31:0]   wt_arr;
  logic [31:0]   data_arr;
  logic [N-1:0]  data_vld;
  logic          busy;
  logic          tile_done;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  ent_t        wq[$];
  ent_t        lq[N][$];
  int unsigned tdq[$];
  logic [31:0] last_wt = '0;
  int unsigned last_td = 0;
  logic [31:0] hist[int unsigned];

  wsa_feeder #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .wt_in     (wt_in),
    .wt_valid  (wt_valid),
    .wt_ready  (wt_ready),
    .act_in    (act_in),
    .act_valid (act_valid),
    .act_last  (act_last),
    .act_ready (act_ready),
    .control   (control),
    .wt_arr    (wt_arr),
    .data_arr  (data_arr),
    .data_vld  (data_vld),
    .busy      (busy),
    .tile_done (tile_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sb_clear();
    wq.delete();
    for (int i = 0; i < N; i++) lq[i].delete();
    tdq.delete();
    last_wt = '0;
  endtask

  // Per-cycle monitor: check what was due this cycle, then queue what this cycle's accepts imply.
  initial begin
    ent_t e;
    logic exp_v;
    logic [7:0] lane;
    forever begin
      @(negedge clk);
      if (reset) begin
        hist[cyc] = data_arr;
        exp_v = (wq.size() > 0) && (wq[0].cyc == cyc);
        chk_eq("control", 64'(control), 64'(exp_v));
        if (exp_v) begin
          e = wq.pop_front();
          chk_eq("wt_arr", 64'(wt_arr), 64'(e.d));
          last_wt = e.d;
        end else begin
          chk_eq("wt_hold", 64'(wt_arr), 64'(last_wt));
        end
        for (int i = 0; i < N; i++) begin
          exp_v = (lq[i].size() > 0) && (lq[i][0].cyc == cyc);
          lane  = data_arr[i*DW +: DW];
          chk_eq($sformatf("data_vld%0d", i), 64'(data_vld[i]), 64'(exp_v));
          if (exp_v) begin
            e = lq[i].pop_front();
            chk_eq($sformatf("lane%0d_data", i), 64'(lane), 64'(e.d));
          end else begin
            chk_eq($sformatf("lane%0d_zero", i), 64'(lane), 64'(0));
          end
        end
        exp_v = (tdq.size() > 0) && (tdq[0] == cyc);
        chk_eq("tile_done", 64'(tile_done), 64'(exp_v));
        if (exp_v) void'(tdq.pop_front());
        if (tile_done) last_td = cyc;
        if (wt_valid && wt_ready) wq.push_back('{cyc + 1, wt_in});
        if (act_valid && act_ready) begin
          for (int i = 0; i < N; i++)
            lq[i].push_back('{cyc + 1 + i, 32'(act_in[i*DW +: DW])});
          if (act_last) tdq.push_back(cyc + N);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_wt(input logic [31:0] row, output int unsigned acc_cyc, output logic ar);
    logic acc;
    acc = 1'b0;
    ar  = 1'b0;
    acc_cyc = 0;
    wt_in = row;
    wt_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = wt_ready;
      acc_cyc = cyc;
      ar = act_ready;
      tick();
    end
    wt_valid = 1'b0;
    chk_eq("wt_accept", 64'(acc), 64'(1));
  endtask

  task automatic send_act(input logic [31:0] vec, input logic last, output int unsigned acc_cyc);
    logic acc;
    acc = 1'b0;
    acc_cyc = 0;
    act_in = vec;
    act_last = last;
    act_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = act_ready;
      acc_cyc = cyc;
      tick();
    end
    act_valid = 1'b0;
    act_last = 1'b0;
    chk_eq("act_accept", 64'(acc), 64'(1));
  endtask

  task automatic load_tile(input int gap);
    int unsigned c;
    logic ar;
    send_wt(32'h05020304, c, ar);
    repeat (gap) tick();
    send_wt(32'h03010203, c, ar);
    repeat (gap) tick();
    send_wt(32'h07040102, c, ar);
    repeat (gap) tick();
    send_wt(32'h01020403, c, ar);
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int k = 0; k < 40 && !idle; k++) begin
      @(negedge clk);
      idle = !busy;
    end
    chk_eq("reach_idle", 64'(idle), 64'(1));
    tick();
  endtask

  logic [31:0] skew_exp [7] = '{32'h00000001, 32'h00000102, 32'h00010200, 32'h00010100,
                                32'h02030200, 32'h04010000, 32'h05000000};

  initial begin
    int unsigned t0, t;
    logic ar;

    // Held in reset: everything quiet.
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_control",  64'(control),  64'(0));
    chk_eq("rst_wt_arr",   64'(wt_arr),   64'(0));
    chk_eq("rst_data_arr", 64'(data_arr), 64'(0));
    chk_eq("rst_data_vld", 64'(data_vld), 64'(0));
    chk_eq("rst_tile_done", 64'(tile_done), 64'(0));
    chk_eq("rst_busy",     64'(busy),     64'(0));
    chk_eq("rst_wt_ready", 64'(wt_ready), 64'(0));
    chk_eq("rst_act_ready", 64'(act_ready), 64'(0));
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk_eq("rel_wt_ready", 64'(wt_ready), 64'(1));
    chk_eq("rel_busy",     64'(busy),     64'(0));
    chk_eq("rel_act_ready", 64'(act_ready), 64'(0));
    tick();

    // Back-to-back weight rows, then back-to-back activations.
    send_wt(32'h05020304, t, ar);
    send_wt(32'h03010203, t, ar);
    send_wt(32'h07040102, t, ar);
    send_wt(32'h01020403, t, ar);
    chk_eq("act_ready_at_row3", 64'(ar), 64'(0));
    @(negedge clk);
    chk_eq("act_ready_after_load", 64'(act_ready), 64'(1));
    chk_eq("busy_stream", 64'(busy), 64'(1));
    tick();
    send_act(32'h00010101, 1'b0, t0);
    send_act(32'h02010202, 1'b0, t);
    send_act(32'h04030100, 1'b0, t);
    send_act(32'h05010200, 1'b1, t);
    wait_idle();
    for (int k = 0; k < 7; k++)
      chk_eq($sformatf("skew_diag%0d", k), 64'(hist[t0 + 1 + k]), 64'(skew_exp[k]));
    chk_eq("skew_td_lat", 64'(last_td - t0), 64'(7));

    // Two bubbles after the first vector.
    load_tile(0);
    send_act(32'h00010101, 1'b0, t0);
    repeat (2) tick();
    send_act(32'h02010202, 1'b0, t);
    send_act(32'h04030100, 1'b0, t);
    send_act(32'h05010200, 1'b1, t);
    wait_idle();
    chk_eq("bubble_diag1", 64'(hist[t0 + 2]), 64'(32'h00000100));
    chk_eq("bubble_td_lat", 64'(last_td - t0), 64'(9));

    // Gapped weight rows with stray act_valid, then stray wt_valid while streaming.
    act_valid = 1'b1;
    act_last = 1'b1;
    act_in = 32'hdeadbeef;
    send_wt(32'h11223344, t, ar);
    tick();
    send_wt(32'h55667788, t, ar);
    tick();
    send_wt(32'h99aabbcc, t, ar);
    @(negedge clk);
    chk_eq("act_ready_loading", 64'(act_ready), 64'(0));
    tick();
    act_valid = 1'b0;
    act_last = 1'b0;
    send_wt(32'hddeeff00, t, ar);
    wt_valid = 1'b1;
    wt_in = 32'hcafef00d;
    repeat (2) begin
      @(negedge clk);
      chk_eq("wt_ready_stream", 64'(wt_ready), 64'(0));
      tick();
    end
    wt_valid = 1'b0;
    send_act(32'h0a0b0c0d, 1'b1, t0);
    wait_idle();
    chk_eq("single_td_lat", 64'(last_td - t0), 64'(4));

    // Reset with two vectors in flight.
    load_tile(0);
    send_act(32'h00010101, 1'b0, t);
    send_act(32'h02010202, 1'b0, t);
    reset = 1'b0;
    sb_clear();
    #1;
    chk_eq("mid_rst_data", 64'(data_arr), 64'(0));
    chk_eq("mid_rst_vld",  64'(data_vld), 64'(0));
    chk_eq("mid_rst_busy", 64'(busy), 64'(0));
    chk_eq("mid_rst_wt",   64'(wt_arr), 64'(0));
    repeat (6) begin
      @(negedge clk);
      chk_eq("mid_rst_td", 64'(tile_done), 64'(0));
    end
    tick();
    reset = 1'b1;
    tick();
    load_tile(0);
    send_act(32'h04030201, 1'b1, t0);
    wait_idle();
    chk_eq("post_rst_td_lat", 64'(last_td - t0), 64'(4));

    repeat (3) tick();
    chk_eq("wq_empty",  64'(wq.size()),  64'(0));
    chk_eq("tdq_empty", 64'(tdq.size()), 64'(0));
    for (int i = 0; i < N; i++)
      chk_eq($sformatf("lq%0d_empty", i), 64'(lq[i].size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
